// File: rtl/ball_engine.sv
// Multi-ball sprite engine: per-frame motion/bounce during vertical blanking and
// a two-stage filled-circle renderer feeding the VGA pins.
module ball_engine #(
  parameter int NUM_BALLS = 4,
  parameter int IDX_W     = 2,
  parameter int RADIUS_W  = 3,
  parameter int STEP_W    = 4,
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [10:0]         vcounter,
  input  logic [11:0]         hcounter,
  input  logic                visible,
  input  logic [RADIUS_W-1:0] radius,
  input  logic                run,
  input  logic                load,
  input  logic [IDX_W-1:0]    load_idx,
  input  logic [10:0]         load_x,
  input  logic [10:0]         load_y,
  input  logic [STEP_W-1:0]   load_dx,
  input  logic [STEP_W-1:0]   load_dy,
  input  logic [2:0]          load_color,
  output logic                update_done,
  output logic                VGA_R,
  output logic                VGA_G,
  output logic                VGA_B
);

  localparam int RW2 = 2 * RADIUS_W;

  typedef enum logic [1:0] {IDLE, UPD, DONE} state_t;

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic [RADIUS_W-1:0]   r_q;
  logic                  cond_q;
  logic                  frame_cond;
  logic                  sof;

  logic [10:0]           bx   [NUM_BALLS];
  logic [10:0]           by   [NUM_BALLS];
  logic [STEP_W-1:0]     bdx  [NUM_BALLS];
  logic [STEP_W-1:0]     bdy  [NUM_BALLS];
  logic [2:0]            bcol [NUM_BALLS];
  logic [NUM_BALLS-1:0]  bact;

  logic [23:0]           sqh1 [NUM_BALLS];
  logic [23:0]           sqv1 [NUM_BALLS];
  logic [2:0]            col1 [NUM_BALLS];
  logic [NUM_BALLS-1:0]  act1;
  logic [RW2-1:0]        rsq1;
  logic                  vis1;
  logic [2:0]            pix;

  // One axis step: returns {new position, new velocity}; bounces clamp to the
  // edge-minus-radius and reverse the velocity.
  function automatic logic [10+STEP_W:0] move_axis(input logic [10:0] p,
                                                   input logic [STEP_W-1:0] d,
                                                   input logic [RADIUS_W-1:0] r,
                                                   input logic [12:0] lim);
    logic signed [12:0] n, lo, hi;
    logic [STEP_W-1:0]  nd;
    n  = $signed({2'b00, p}) + $signed({{(13-STEP_W){d[STEP_W-1]}}, d});
    lo = $signed({{(13-RADIUS_W){1'b0}}, r});
    hi = $signed(lim) - 13'sd1 - lo;
    nd = -d;
    if (d[STEP_W-1] && (n < lo)) return {lo[10:0], nd};
    else if (!d[STEP_W-1] && (d != '0) && (n > hi)) return {hi[10:0], nd};
    else return {n[10:0], d};
  endfunction

  function automatic logic [11:0] absdiff(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [23:0] sq12(input logic [11:0] a);
    return {12'd0, a} * {12'd0, a};
  endfunction

  assign frame_cond = (vcounter == 11'(V_ACTIVE)) && (hcounter == 12'd0);
  assign sof        = frame_cond && !cond_q;

  // Frame-update FSM and ball slot storage; a load is written last so it wins
  // over the update of the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      update_done <= 1'b0;
      r_q         <= '0;
      cond_q      <= 1'b0;
      bact        <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        bx[i]   <= 11'd0;
        by[i]   <= 11'd0;
        bdx[i]  <= '0;
        bdy[i]  <= '0;
        bcol[i] <= 3'd0;
      end
    end else begin
      cond_q      <= frame_cond;
      update_done <= 1'b0;
      case (state)
        IDLE: begin
          if (sof) begin
            state <= UPD;
            idx   <= '0;
            r_q   <= radius;
          end
        end
        UPD: begin
          if (bact[idx] && run) begin
            {bx[idx], bdx[idx]} <= move_axis(bx[idx], bdx[idx], r_q, 13'(H_ACTIVE));
            {by[idx], bdy[idx]} <= move_axis(by[idx], bdy[idx], r_q, 13'(V_ACTIVE));
          end
          if (idx == IDX_W'(NUM_BALLS - 1)) begin
            state       <= DONE;
            update_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (load && (32'(load_idx) < NUM_BALLS)) begin
        bx[load_idx]   <= load_x;
        by[load_idx]   <= load_y;
        bdx[load_idx]  <= load_dx;
        bdy[load_idx]  <= load_dy;
        bcol[load_idx] <= load_color;
        bact[load_idx] <= 1'b1;
      end
    end
  end

  // Draw stage 1: squared distances per ball plus the context they are judged against.
  always_ff @(posedge clk) begin
    if (rst) begin
      vis1 <= 1'b0;
      act1 <= '0;
      rsq1 <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        sqh1[i] <= 24'd0;
        sqv1[i] <= 24'd0;
        col1[i] <= 3'd0;
      end
    end else begin
      vis1 <= visible;
      act1 <= bact;
      rsq1 <= RW2'(r_q) * RW2'(r_q);
      for (int i = 0; i < NUM_BALLS; i++) begin
        sqh1[i] <= sq12(absdiff(hcounter, {1'b0, bx[i]}));
        sqv1[i] <= sq12(absdiff({1'b0, vcounter}, {1'b0, by[i]}));
        col1[i] <= bcol[i];
      end
    end
  end

  // Draw stage 2 compare: descending scan so the lowest-index hit is left standing.
  always_comb begin
    pix = 3'b000;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      pix = (act1[i] && (({1'b0, sqh1[i]} + {1'b0, sqv1[i]}) <= 25'(rsq1))) ? col1[i] : pix;
    end
  end

  // Draw stage 2 output register, blanked outside active video.
  always_ff @(posedge clk) begin
    if (rst) begin
      {VGA_R, VGA_G, VGA_B} <= 3'b000;
    end else begin
      {VGA_R, VGA_G, VGA_B} <= vis1 ? pix : 3'b000;
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: cycle-level reference model, a motion table,
// directed corner sequences and randomized traffic.
module tb_ball_engine;

  localparam int NB    = 4;
  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  logic        clk, rst;
  logic [10:0] vcounter;
  logic [11:0] hcounter;
  logic        visible;
  logic [2:0]  radius;
  logic        run, load;
  logic [1:0]  load_idx;
  logic [10:0] load_x, load_y;
  logic [3:0]  load_dx, load_dy;
  logic [2:0]  load_color;
  logic        update_done, VGA_R, VGA_G, VGA_B;

  ball_engine dut (
    .clk(clk), .rst(rst), .vcounter(vcounter), .hcounter(hcounter), .visible(visible),
    .radius(radius), .run(run), .load(load), .load_idx(load_idx), .load_x(load_x),
    .load_y(load_y), .load_dx(load_dx), .load_dy(load_dy), .load_color(load_color),
    .update_done(update_done), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int mx[NB], my[NB], mdx[NB], mdy[NB], mcol[NB];
  bit mact[NB];
  int mrq;
  bit cond_prev;
  int upd_start = -1000;
  int cyc = 0;
  int prev_exp = 0;

  typedef struct {
    int slot, x, y, dx, dy, r, run, frames, ex, ey;
  } mv_t;
  mv_t tbl[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_pix(input int h, input int v, input bit vis);
    if (!vis) return 0;
    for (int i = 0; i < NB; i++)
      if (mact[i] && ((h - mx[i]) * (h - mx[i]) + (v - my[i]) * (v - my[i]) <= mrq * mrq))
        return mcol[i];
    return 0;
  endfunction

  function automatic void move(input int p, input int d, input int r, input int lim,
                               output int np, output int nd);
    int n;
    n = p + d;
    if (d < 0 && n < r) begin np = r; nd = -d; end
    else if (d > 0 && n > lim - 1 - r) begin np = lim - 1 - r; nd = -d; end
    else begin np = n; nd = d; end
  endfunction

  // Advance one clock: predict this cycle in the model, clock, then compare.
  task automatic tick();
    int e, chk, k, np, nd;
    bit cnd, sof, busy;
    e   = model_pix(int'(hcounter), int'(vcounter), visible);
    chk = rst ? 0 : prev_exp;
    prev_exp = rst ? 0 : e;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0; mcol[i] = 0; mact[i] = 0;
      end
      mrq = 0; cond_prev = 0; upd_start = -1000;
    end else begin
      cnd  = (int'(vcounter) == V_ACT) && (hcounter == 12'd0);
      sof  = cnd && !cond_prev;
      cond_prev = cnd;
      busy = (cyc - upd_start >= 1) && (cyc - upd_start <= NB + 1);
      k    = cyc - upd_start - 1;
      if (k >= 0 && k < NB && mact[k] && run) begin
        move(mx[k], mdx[k], mrq, H_ACT, np, nd); mx[k] = np; mdx[k] = nd;
        move(my[k], mdy[k], mrq, V_ACT, np, nd); my[k] = np; mdy[k] = nd;
      end
      if (load && int'(load_idx) < NB) begin
        mx[load_idx] = int'(load_x);  my[load_idx] = int'(load_y);
        mdx[load_idx] = int'($signed(load_dx)); mdy[load_idx] = int'($signed(load_dy));
        mcol[load_idx] = int'(load_color); mact[load_idx] = 1;
      end
      if (sof && !busy) begin
        upd_start = cyc;
        mrq = int'(radius);
      end
    end
    @(posedge clk); #1;
    cyc++;
    check("vga", int'({VGA_R, VGA_G, VGA_B}), chk);
    check("update_done", int'(update_done), (cyc - upd_start == NB + 1) ? 1 : 0);
  endtask

  task automatic idle_in();
    vcounter = 11'd0; hcounter = 12'd1; visible = 1'b0; load = 1'b0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  task automatic load_slot(input int s, input int x, input int y, input int dx,
                           input int dy, input int col);
    load = 1'b1; load_idx = 2'(s); load_x = 11'(x); load_y = 11'(y);
    load_dx = 4'(dx); load_dy = 4'(dy); load_color = 3'(col);
    tick();
    load = 1'b0;
  endtask

  task automatic frame();
    int cnt;
    cnt = 0;
    visible = 1'b0; vcounter = 11'(V_ACT); hcounter = 12'd1;
    tick(); cnt += int'(update_done);
    hcounter = 12'd0;
    tick(); cnt += int'(update_done);
    hcounter = 12'd1;
    repeat (NB + 2) begin tick(); cnt += int'(update_done); end
    check("done_per_frame", cnt, 1);
    idle_in();
  endtask

  task automatic probe(input int h, input int v, input bit vis, output int px);
    hcounter = 12'(h); vcounter = 11'(v); visible = vis;
    tick();
    idle_in();
    tick();
    px = int'({VGA_R, VGA_G, VGA_B});
  endtask

  initial begin
    int px, cnt;
    rst = 1'b1; radius = 3'd0; run = 1'b0; load_idx = 2'd0; load_x = 11'd0; load_y = 11'd0;
    load_dx = 4'd0; load_dy = 4'd0; load_color = 3'd0;
    idle_in();
    tick(); tick(); tick();
    rst = 1'b0;
    check("reset_vga", int'({VGA_R, VGA_G, VGA_B}), 0);
    check("reset_done", int'(update_done), 0);

    // empty screen after a frame
    frame();
    probe(320, 240, 1'b1, px); check("empty_black", px, 0);
    frame();

    // single red ball, count circle pixels
    load_slot(0, 100, 100, 0, 0, 4);
    radius = 3'd3;
    frame();
    cnt = 0;
    for (int dv = -5; dv <= 5; dv++)
      for (int dh = -5; dh <= 5; dh++) begin
        hcounter = 12'(100 + dh); vcounter = 11'(100 + dv); visible = 1'b1;
        tick();
        cnt += ({VGA_R, VGA_G, VGA_B} == 3'b100) ? 1 : 0;
      end
    idle_in();
    tick(); cnt += ({VGA_R, VGA_G, VGA_B} == 3'b100) ? 1 : 0;
    tick(); cnt += ({VGA_R, VGA_G, VGA_B} == 3'b100) ? 1 : 0;
    check("circle_hits", cnt, 29);
    probe(100, 100, 1'b0, px); check("blank_invisible", px, 0);
    probe(100, 100, 1'b1, px); check("centre_red", px, 4);

    // motion / bounce table
    tbl[0] = '{0,   6, 100, -4,  0, 3, 1, 1,   3, 100};
    tbl[1] = '{0,   6, 100, -4,  0, 3, 1, 2,   7, 100};
    tbl[2] = '{1, 634, 100,  3,  0, 3, 1, 1, 636, 100};
    tbl[3] = '{1, 634, 100,  3,  0, 3, 1, 2, 633, 100};
    tbl[4] = '{1, 634, 100,  3,  0, 3, 0, 2, 634, 100};
    tbl[5] = '{2, 200,   4,  0, -3, 3, 1, 1, 200,   3};
    tbl[6] = '{3, 300, 474,  0,  5, 2, 1, 1, 300, 477};
    tbl[7] = '{0,  50,  60,  5, -2, 1, 1, 3,  65,  54};
    for (int t = 0; t < 8; t++) begin
      do_reset();
      radius = 3'(tbl[t].r);
      run    = 1'(tbl[t].run);
      load_slot(tbl[t].slot, tbl[t].x, tbl[t].y, tbl[t].dx, tbl[t].dy, 2);
      for (int f = 0; f < tbl[t].frames; f++) frame();
      probe(tbl[t].ex + tbl[t].r,     tbl[t].ey, 1'b1, px); check("tbl_x_hi_in",  px, 2);
      probe(tbl[t].ex - tbl[t].r,     tbl[t].ey, 1'b1, px); check("tbl_x_lo_in",  px, 2);
      probe(tbl[t].ex + tbl[t].r + 1, tbl[t].ey, 1'b1, px); check("tbl_x_hi_out", px, 0);
      probe(tbl[t].ex - tbl[t].r - 1, tbl[t].ey, 1'b1, px); check("tbl_x_lo_out", px, 0);
      probe(tbl[t].ex, tbl[t].ey + tbl[t].r,     1'b1, px); check("tbl_y_hi_in",  px, 2);
      probe(tbl[t].ex, tbl[t].ey - tbl[t].r,     1'b1, px); check("tbl_y_lo_in",  px, 2);
      probe(tbl[t].ex, tbl[t].ey + tbl[t].r + 1, 1'b1, px); check("tbl_y_hi_out", px, 0);
      probe(tbl[t].ex, tbl[t].ey - tbl[t].r - 1, 1'b1, px); check("tbl_y_lo_out", px, 0);
    end

    // priority, then load colliding with the update of the same slot
    do_reset();
    run = 1'b0; radius = 3'd3;
    load_slot(0, 100, 100, 0, 0, 4);
    load_slot(2, 100, 100, 5, 0, 1);
    frame();
    probe(100, 100, 1'b1, px); check("priority_red", px, 4);
    run = 1'b1;
    vcounter = 11'(V_ACT); hcounter = 12'd1; tick();
    hcounter = 12'd0; tick();
    hcounter = 12'd1; tick(); tick();
    load = 1'b1; load_idx = 2'd2; load_x = 11'd400; load_y = 11'd300;
    load_dx = 4'd2; load_dy = 4'd0; load_color = 3'd1;
    tick();
    load = 1'b0;
    repeat (NB) tick();
    idle_in();
    probe(400, 300, 1'b1, px); check("loadwin_centre", px, 1);
    probe(397, 300, 1'b1, px); check("loadwin_lo_in",  px, 1);
    probe(396, 300, 1'b1, px); check("loadwin_lo_out", px, 0);
    probe(403, 300, 1'b1, px); check("loadwin_hi_in",  px, 1);
    probe(404, 300, 1'b1, px); check("loadwin_hi_out", px, 0);

    // reset in the middle of an update
    do_reset();
    radius = 3'd3; run = 1'b1;
    load_slot(0, 100, 100, 1, 0, 4);
    frame();
    vcounter = 11'(V_ACT); hcounter = 12'd1; tick();
    hcounter = 12'd0; tick();
    hcounter = 12'd1; tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    idle_in();
    cnt = 0;
    repeat (NB + 3) begin tick(); cnt += int'(update_done); end
    check("done_after_abort", cnt, 0);
    frame();
    probe(101, 100, 1'b1, px); check("black_after_abort", px, 0);

    // randomized traffic against the model
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      int sel, k, hh, vv, dx, dy;
      sel  = int'($urandom_range(0, 99));
      rst  = ($urandom_range(0, 499) == 0);
      load = 1'b0;
      if (sel < 6) begin
        dx = int'($urandom_range(0, 14)) - 7;
        dy = int'($urandom_range(0, 14)) - 7;
        load = 1'b1; load_idx = 2'($urandom_range(0, 3));
        load_x = 11'($urandom_range(0, 700)); load_y = 11'($urandom_range(0, 520));
        load_dx = 4'(dx); load_dy = 4'(dy); load_color = 3'($urandom_range(0, 7));
      end
      if (sel >= 6 && sel < 9) begin
        vcounter = 11'(V_ACT); hcounter = 12'd0; visible = 1'b0;
      end else begin
        k  = int'($urandom_range(0, 3));
        hh = mx[k] + int'($urandom_range(0, 16)) - 8;
        vv = my[k] + int'($urandom_range(0, 16)) - 8;
        hcounter = 12'(hh); vcounter = 11'(vv);
        visible = ($urandom_range(0, 3) != 0);
      end
      if (sel == 99) radius = 3'($urandom_range(0, 7));
      if (sel == 98) run = ~run;
      tick();
    end
    rst = 1'b0;
    idle_in();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
# ball_engine

Multi-ball sprite engine for the VGA datapath: holds position, velocity and colour for `NUM_BALLS` balls, moves and bounces them once per frame during vertical blanking, and renders filled circles into the pixel stream. It sits between the VGA sync counter block and the VGA pins, replacing the single static ball drawer. Pixel output is registered with a fixed two-cycle latency.

## Interface
Parameters:
- `NUM_BALLS`, 4: number of ball slots (1–8).
- `IDX_W`, 2: ball index width, max(1, clog2(NUM_BALLS)).
- `RADIUS_W`, 3: radius width.
- `STEP_W`, 4: signed velocity width (two's complement, pixels/frame).
- `H_ACTIVE`, 640: visible width.
- `V_ACTIVE`, 480: visible height.

Ports:
- `clk` in 1: pixel clock, the only clock.
- `rst` in 1: synchronous, active-high reset.
- `vcounter` in 11: current line from the sync block.
- `hcounter` in 12: current pixel from the sync block.
- `visible` in 1: active video flag for the current counters.
- `radius` in RADIUS_W: radius shared by all balls.
- `run` in 1: 1 = apply motion at frame update; 0 = freeze positions.
- `load` in 1: write one ball slot this cycle.
- `load_idx` in IDX_W: slot to write.
- `load_x`, `load_y` in 11: initial centre.
- `load_dx`, `load_dy` in STEP_W: signed velocity.
- `load_color` in 3: {R,G,B}.
- `update_done` out 1: one-cycle pulse when the frame update finishes.
- `VGA_R`, `VGA_G`, `VGA_B` out 1: pixel colour.

## Operation
- Per slot: `x`, `y` (11 b), `dx`, `dy` (STEP_W signed), `color` (3 b), `active`. `load` writes all of them and sets `active`. `load_idx >= NUM_BALLS` is ignored.
- Frame start: `sof` is 1 in the cycle where (`vcounter == V_ACTIVE && hcounter == 0`) becomes true; it is a registered edge and fires once per frame. On `sof`, `radius` is latched into `r_q`, which is used for the next frame's motion and drawing.
- Update FSM states:
  - IDLE: on `sof`, go to UPD with `idx = 0`.
  - UPD: process slot `idx`, one slot per cycle. After `idx == NUM_BALLS-1`, go to DONE.
  - DONE: pulse `update_done` and return to IDLE.
- Motion per axis, only if `active && run`, with limit L = `H_ACTIVE` or `V_ACTIVE`. Compute signed in 13 bits: n = p + d.
  - If d < 0 and n < r_q: p = r_q and d = −d.
  - Else if d > 0 and n > L−1−r_q: p = L−1−r_q and d = −d.
  - Else p = n.
  - d = 0 leaves the axis unchanged.
- `load` to the slot being updated in the same cycle: the load wins. A `load` in any other cycle always takes effect.
- `sof` while not IDLE is ignored. This cannot occur with legal sync timing.
- Draw: a pixel hits ball i if `active[i]` and (h−x)²+(v−y)² ≤ r_q², computed unsigned on 24-bit squares. The lowest-index hit wins. Output is that ball's colour if `visible`, else 3'b000. No hit gives black.

## Timing
- Reset: all slots inactive with zeroed fields, `r_q = 0`, FSM IDLE, `update_done = 0`, `VGA_* = 0`.
- Draw pipeline:
  - Stage 1 registers the differences, their squares and `visible`.
  - Stage 2 registers the compare, priority and colour.
  - `VGA_*` at cycle t+2 reflects the counters at cycle t.
- The update runs in the cycles `sof`+1 … `sof`+NUM_BALLS. `update_done` is asserted at `sof`+NUM_BALLS+1. All of this falls within vertical blanking, so no visible pixel sees a partial update.
- Reset asserted mid-update aborts it: state returns to reset values the next cycle and no `update_done` is issued.

## Test plan
- Reset, then sweep one frame → all `VGA_*` = 0, `update_done` pulses once per frame at `sof`+NUM_BALLS+1.
- Load slot 0: x=100, y=100, color=3'b100, `radius`=3. Scan the frame → red exactly where dist² ≤ 9 (29 pixels), output two cycles after the counters, black when `visible`=0.
- Slot 0 at x=6, dx=−4, r=3, `run`=1 → next frame x=3, dx=+4; following frame x=7.
- Slot 1 at x=634, dx=+3, r=3, H_ACTIVE=640 → x=636, dx=−3; a repeat with `run`=0 leaves x and dx unchanged.
- Overlapping slots 0 (red) and 2 (blue) at the same centre → red wins. Then `load` slot 2 in the same cycle the FSM updates slot 2 → the loaded values are kept unmodified.
- Assert `rst` during UPD → no `update_done`, all slots inactive, screen black the next frame.
